// File: rtl/xor_txn_pkg.sv
// Shared types and constants for the XOR transaction driver: FSM states and
// the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) helpers.
package xor_txn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Feedback taps at bits 7,5,4,3 for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced
    function automatic logic [7:0] lfsr_seed(input logic [7:0] s);
        return (s == 8'h00) ? LFSR_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/xor_txn_expq.sv
// Expected-result queue: 1-bit synchronous FIFO of DEPTH entries (power of two)
// with first-word fall-through read data and a synchronous flush.
module xor_txn_expq #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/xor_txn_driver.sv
// Drives LFSR operand pairs into an XOR DUT's input FIFO and collects results.
// Define XOR_TXN_SCOREBOARD_EN to build the expected queue and result checking.
module xor_txn_driver
    import xor_txn_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int EXP_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       seed,
    output logic [1:0]       din,
    output logic             wr_en,
    input  logic             full,
    input  logic [1:0]       dout,
    output logic             rd_en,
    input  logic             empty,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] recv_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] sent_q;
    logic [7:0]       lfsr_q;
    logic             rd_vld;
    logic             start_ok;
    logic             exp_full;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign din      = lfsr_q[1:0];

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy  = 1'b1;
                wr_en = (sent_q < count_q) && !full && !exp_full;
                rd_en = !empty;
                if (sent_q == count_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy  = 1'b1;
                rd_en = !empty;
                if (recv_cnt == count_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start_ok) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rd_vld marks the cycle in which dout holds the word requested by rd_en
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= '0;
            sent_q   <= '0;
            recv_cnt <= '0;
            lfsr_q   <= LFSR_ZERO_SUB;
            rd_vld   <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            if (start_ok) begin
                count_q  <= count;
                sent_q   <= '0;
                recv_cnt <= '0;
                lfsr_q   <= lfsr_seed(seed);
            end else begin
                if (wr_en) begin
                    sent_q <= sent_q + 1'b1;
                    lfsr_q <= lfsr_step(lfsr_q);
                end
                if (rd_vld) recv_cnt <= recv_cnt + 1'b1;
            end
        end
    end

`ifdef XOR_TXN_SCOREBOARD_EN
    logic exp_bit;
    logic exp_empty;
    logic mismatch;

    xor_txn_expq #(
        .DEPTH (EXP_DEPTH)
    ) u_expq (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .push  (wr_en),
        .din   (din[1] ^ din[0]),
        .pop   (rd_vld),
        .dout  (exp_bit),
        .full  (exp_full),
        .empty (exp_empty)
    );

    // A result with nothing outstanding is itself an error
    assign mismatch = exp_empty || (dout[0] != exp_bit) || dout[1];

    always_ff @(posedge clk) begin
        if (!rst || start_ok) begin
            err_cnt <= '0;
        end else if (rd_vld && mismatch && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    logic dout_unused;

    assign exp_full    = 1'b0;
    assign err_cnt     = '0;
    assign dout_unused = ^dout;
`endif

endmodule

// File: tb/tb_xor_txn_driver.sv
// Self-checking bench for xor_txn_driver: an XOR DUT model with 2-cycle latency
// and FIFO behaviour, plus a scoreboard of expected operand pairs.
module tb_xor_txn_driver;

    localparam int CNT_W     = 8;
    localparam int EXP_DEPTH = 8;

`ifdef XOR_TXN_SCOREBOARD_EN
    localparam int EXP_INV_ERR   = 16;
    localparam int EXP_BP_WRITES = 8;
`else
    localparam int EXP_INV_ERR   = 0;
    localparam int EXP_BP_WRITES = 16;
`endif

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic             full  = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [7:0]       seed  = '0;
    logic [1:0]       din;
    logic [1:0]       dout  = 2'b00;
    logic             wr_en;
    logic             rd_en;
    logic             empty;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] recv_cnt;
    logic [CNT_W-1:0] err_cnt;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];

    // DUT model state
    logic       stall  = 1'b0;
    logic       invert = 1'b0;
    logic       s_wr   = 1'b0;
    logic       s_rd   = 1'b0;
    logic       s_rst  = 1'b0;
    logic       s_viol = 1'b0;
    logic [1:0] s_din  = 2'b00;
    logic       p0_v   = 1'b0;
    logic       p1_v   = 1'b0;
    logic [1:0] p0_d   = 2'b00;
    logic [1:0] p1_d   = 2'b00;
    logic [1:0] out_q[$];
    int         out_cnt  = 0;
    int         n_writes = 0;
    int         viol     = 0;

    xor_txn_driver #(
        .CNT_W     (CNT_W),
        .EXP_DEPTH (EXP_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .seed     (seed),
        .din      (din),
        .wr_en    (wr_en),
        .full     (full),
        .dout     (dout),
        .rd_en    (rd_en),
        .empty    (empty),
        .busy     (busy),
        .done     (done),
        .recv_cnt (recv_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    assign empty = stall || (out_cnt == 0);

    // Strobes are sampled mid-cycle and acted on just after the following edge
    always @(negedge clk) begin
        s_wr   = wr_en && rst;
        s_rd   = rd_en && rst;
        s_din  = din;
        s_rst  = rst;
        s_viol = (wr_en || rd_en) && !busy;
    end

    always @(posedge clk) begin
        #1;
        if (!s_rst) begin
            p0_v = 1'b0;
            p1_v = 1'b0;
            out_q.delete();
        end else begin
            if (s_rd && out_q.size() > 0) dout = out_q.pop_front();
            if (p1_v) out_q.push_back(p1_d);
            p1_v = p0_v;
            p1_d = p0_d;
            p0_v = s_wr;
            p0_d = {1'b0, (s_din[1] ^ s_din[0]) ^ invert};
            if (s_wr) n_writes++;
        end
        if (s_viol) viol++;
        out_cnt = out_q.size();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    function automatic logic [7:0] m_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic cycle();
        logic [1:0] e;
        @(negedge clk);
        if (wr_en === 1'b1 && rst === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_din: write with din=%b, expected no write", din);
            end else begin
                e = exp_q.pop_front();
                if (din !== e) begin
                    errors++;
                    $display("FAIL sb_din: din=%b expected=%b", din, e);
                end
            end
        end
    endtask

    task automatic do_start(input logic [CNT_W-1:0] cnt, input logic [7:0] sd);
        logic [7:0] s;
        s = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < int'(cnt); i++) begin
            exp_q.push_back(s[1:0]);
            s = m_next(s);
        end
        @(posedge clk); #1;
        count = cnt;
        seed  = sd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
        end
    endtask

    task automatic end_of_run(input string tag, input int base_w, input int n_exp,
                              input int err_exp);
        checks++;
        if (n_writes - base_w != n_exp) begin
            errors++;
            $display("FAIL %s_writes: got %0d expected %0d", tag, n_writes - base_w, n_exp);
        end
        checks++;
        if (recv_cnt !== CNT_W'(n_exp)) begin
            errors++;
            $display("FAIL %s_recv: recv_cnt=%0d expected %0d", tag, recv_cnt, n_exp);
        end
        checks++;
        if (err_cnt !== CNT_W'(err_exp)) begin
            errors++;
            $display("FAIL %s_err: err_cnt=%0d expected %0d", tag, err_cnt, err_exp);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left: %0d pairs unsent, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({wr_en, rd_en, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_strobes: {wr,rd,busy,done}=%b expected 0000", tag,
                     {wr_en, rd_en, busy, done});
        end
        checks++;
        if (din !== 2'b01) begin
            errors++;
            $display("FAIL %s_din: din=%b expected 01", tag, din);
        end
        checks++;
        if (recv_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL %s_cnts: recv=%0d err=%0d expected 0 0", tag, recv_cnt, err_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_zero_count();
        int base_w = n_writes;
        int base_v = viol;
        do_start('0, 8'h11);
        cycle();
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL zero_run: {busy,done}=%b expected 10", {busy, done});
        end
        cycle();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_early: done=%b expected 0 one cycle after start", done);
        end
        cycle();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b expected 1 two cycles after start", done);
        end
        end_of_run("zero", base_w, 0, 0);
        checks++;
        if (viol != base_v) begin
            errors++;
            $display("FAIL zero_strobes: %0d strobes outside busy, expected 0", viol - base_v);
        end
    endtask

    task automatic test_basic();
        int base_w = n_writes;
        int base_v = viol;
        do_start(CNT_W'(16), 8'h5A);
        wait_done(300);
        end_of_run("basic", base_w, 16, 0);
        checks++;
        if (viol != base_v) begin
            errors++;
            $display("FAIL basic_strobes: %0d strobes outside busy, expected 0", viol - base_v);
        end
    endtask

    task automatic test_inverted();
        int base_w = n_writes;
        invert = 1'b1;
        do_start(CNT_W'(16), 8'hC3);
        wait_done(300);
        end_of_run("inverted", base_w, 16, EXP_INV_ERR);
        invert = 1'b0;
    endtask

    task automatic test_full_stall();
        int base_w = n_writes;
        int n = 0;
        do_start(CNT_W'(16), 8'h33);
        while (n_writes - base_w < 3 && n < 50) begin
            cycle();
            n++;
        end
        @(posedge clk); #1;
        full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (wr_en !== 1'b0 || exp_q.size() == 0 || din !== exp_q[0]) begin
                errors++;
                $display("FAIL full_freeze: cycle %0d wr_en=%b din=%b expected wr_en=0 din=%b",
                         i, wr_en, din, (exp_q.size() > 0) ? exp_q[0] : 2'bxx);
            end
        end
        @(posedge clk); #1;
        full = 1'b0;
        wait_done(300);
        end_of_run("full", base_w, 16, 0);
    endtask

    task automatic test_back_pressure();
        int base_w = n_writes;
        stall = 1'b1;
        do_start(CNT_W'(16), 8'hA7);
        repeat (30) cycle();
        checks++;
        if (n_writes - base_w != EXP_BP_WRITES || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_stop: writes=%0d wr_en=%b expected %0d and 0",
                     n_writes - base_w, wr_en, EXP_BP_WRITES);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        wait_done(300);
        end_of_run("bp", base_w, 16, 0);
    endtask

    task automatic test_mid_reset();
        int base_w;
        int n = 0;
        do_start(CNT_W'(16), 8'h77);
        while (16 - exp_q.size() < 5 && n < 50) begin
            cycle();
            n++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        repeat (3) cycle();
        checks++;
        if ({wr_en, rd_en, busy} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_quiet: {wr,rd,busy}=%b expected 000", {wr_en, rd_en, busy});
        end
        base_w = n_writes;
        do_start(CNT_W'(4), 8'h00);
        wait_done(100);
        end_of_run("restart", base_w, 4, 0);
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_basic();
        test_inverted();
        test_full_stall();
        test_back_pressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor_txn_driver.md
XOR_TXN_DRIVER -- requirements
Module: xor_txn_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the transaction count and of the received and error counters.
REQ-002 SHALL have parameter EXP_DEPTH, default 8: expected-result queue depth, a power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle run request.
REQ-006 SHALL have port count  input  CNT_W  number of operand pairs to send.
REQ-007 SHALL have port seed  input  8  LFSR seed.
REQ-008 SHALL have port din  output  2  operand pair {a,b} toward the DUT input FIFO.
REQ-009 SHALL have port wr_en  output  1  write strobe toward the DUT input FIFO.
REQ-010 SHALL have port full  input  1  DUT input FIFO full.
REQ-011 SHALL have port dout  input  2  result word from the DUT output FIFO; bit0 = XOR, bit1 = 0.
REQ-012 SHALL have port rd_en  output  1  read strobe toward the DUT output FIFO.
REQ-013 SHALL have port empty  input  1  DUT output FIFO empty.
REQ-014 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port recv_cnt  output  CNT_W  results received.
REQ-017 SHALL have port err_cnt  output  CNT_W  mismatches, saturating at all-ones.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN and DONE.
REQ-019 On start in IDLE or DONE, SHALL latch count, load the LFSR with seed (8'h00 replaced by 8'h01), clear sent, recv_cnt and err_cnt, and enter RUN; start in RUN or DRAIN is ignored.
REQ-020 SHALL go RUN->DRAIN when sent==count and DRAIN->DONE when recv_cnt==count; count=0 therefore reaches DONE two cycles after start.
REQ-021 SHALL use the Fibonacci LFSR x^8+x^6+x^5+x^4+1, with din = lfsr[1:0] and the LFSR advancing only on an accepted write.
REQ-022 wr_en SHALL be combinational: high iff state==RUN, sent<count, !full and the expected queue is not full.
REQ-023 Each write SHALL push din[1]^din[0] into the expected queue and increment sent in the same cycle.
REQ-024 rd_en SHALL be high iff state is RUN or DRAIN and !empty.
REQ-025 dout SHALL be sampled the cycle after rd_en (one-cycle FIFO read latency), tracked by the registered flag rd_vld.
REQ-026 On rd_vld, SHALL increment recv_cnt and pop the expected queue.
REQ-027 Pushing and popping the expected queue in the same cycle SHALL be legal and leave its occupancy unchanged.
REQ-028 If rd_vld occurs with the expected queue empty, SHALL count one error, and recv_cnt SHALL still increment.
REQ-029 SHALL never assert wr_en or rd_en in IDLE or DONE.

Reset
REQ-030 While rst==0 at a clock edge, SHALL set state=IDLE, lfsr=8'h01, sent=0, recv_cnt=0, err_cnt=0, rd_vld=0, expected queue empty, and wr_en=rd_en=busy=done=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no further strobes, and the first start after reset SHALL behave identically to a start from power-up.

Configuration
REQ-032 With XOR_TXN_SCOREBOARD_EN defined, SHALL compare on each rd_vld and count a mismatch when dout[0]!=expected or dout[1]!=0.
REQ-033 With XOR_TXN_SCOREBOARD_EN undefined, the expected queue and comparator SHALL be absent, err_cnt SHALL be tied to 0, and wr_en SHALL ignore the queue-full term.

Structure
REQ-034 Package xor_txn_pkg SHALL hold the state enumeration, the LFSR tap mask, and the LFSR zero-seed substitute 8'h01.
REQ-035 The expected queue SHALL be the sub-module xor_txn_expq (1-bit synchronous FIFO, EXP_DEPTH entries, push/pop/full/empty).

Verification
REQ-036 Scenario: count=0, start -> done=1 two cycles later; wr_en and rd_en never high; err_cnt=0.
REQ-037 Scenario: count=16, seed=8'h5A, correct XOR model with 2-cycle latency -> exactly 16 wr_en pulses, recv_cnt=16, err_cnt=0, done=1.
REQ-038 Scenario: count=16, model returning inverted XOR -> err_cnt=16 with SCOREBOARD_EN defined, and err_cnt=0 with it undefined.
REQ-039 Scenario: full held high for 10 cycles during RUN -> wr_en=0 throughout, din/LFSR frozen, and the run completes with 16 results.
REQ-040 Scenario: model stalls output (empty=1) after 8 writes -> wr_en stops at sent=8 (queue full) and resumes when results drain.
REQ-041 Scenario: rst=0 for 1 cycle at sent=5 -> next cycle all outputs at reset values, and a fresh start with count=4 completes with recv_cnt=4.
